// File: rtl/debounce_pulse.sv
// Push-button conditioner: two-flop synchroniser, debounce FSM, and a one-cycle incr pulse per qualified press.
// Defining DEBOUNCE_AUTOREPEAT_EN adds auto-repeat pulses while the button is held.
module debounce_pulse #(
    parameter int STABLE_CYCLES = 16,
    parameter int REPEAT_DELAY  = 32,
    parameter int REPEAT_PERIOD = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic incr,
    output logic btn_level
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] STABLE_VAL = CNT_W'(STABLE_CYCLES);
    localparam bit SINGLE_SAMPLE = (STABLE_CYCLES == 1);

    if (STABLE_CYCLES < 1) begin : g_bad_stable
        $error("debounce_pulse: STABLE_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             incr_q, incr_d;
    logic             btn_level_q, btn_level_d;
    logic             commit;
    logic             rpt_fire;
    logic             s;

    assign s = sync_q[1];

    always_comb begin
        sync_d      = {sync_q[0], btn_in};
        state_d     = state_q;
        cnt_d       = '0;
        commit      = 1'b0;
        cnt_inc     = cnt_q + CNT_W'(1);
        case (state_q)
            RELEASED: begin
                if (s) begin
                    if (SINGLE_SAMPLE) begin
                        state_d = PRESSED;
                        commit  = 1'b1;
                    end else begin
                        state_d = PRESS_WAIT;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_d = RELEASED;
                end else if (cnt_inc == STABLE_VAL) begin
                    state_d = PRESSED;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            PRESSED: begin
                if (!s) begin
                    if (SINGLE_SAMPLE) begin
                        state_d = RELEASED;
                    end else begin
                        state_d = RELEASE_WAIT;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            RELEASE_WAIT: begin
                // Bounce back to PRESSED is a continuation of the same press, so no pulse
                if (s) begin
                    state_d = PRESSED;
                end else if (cnt_inc == STABLE_VAL) begin
                    state_d = RELEASED;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = RELEASED;
        endcase
        btn_level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
        incr_d      = commit | rpt_fire;
    end

`ifdef DEBOUNCE_AUTOREPEAT_EN
    if (REPEAT_DELAY < 1) begin : g_bad_delay
        $error("debounce_pulse: REPEAT_DELAY must be >= 1");
    end
    if (REPEAT_PERIOD < 1) begin : g_bad_period
        $error("debounce_pulse: REPEAT_PERIOD must be >= 1");
    end

    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] DELAY_VAL  = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] PERIOD_VAL = RPT_W'(REPEAT_PERIOD);

    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d, rpt_inc;
    logic             rpt_armed_q, rpt_armed_d;

    // Counter is zero outside a held press; armed marks that the initial delay has elapsed
    always_comb begin
        rpt_cnt_d   = '0;
        rpt_armed_d = 1'b0;
        rpt_fire    = 1'b0;
        rpt_inc     = rpt_cnt_q + RPT_W'(1);
        if ((state_q == PRESSED || state_q == RELEASE_WAIT) && state_d != RELEASED) begin
            rpt_cnt_d   = rpt_inc;
            rpt_armed_d = rpt_armed_q;
            if (rpt_inc == (rpt_armed_q ? PERIOD_VAL : DELAY_VAL)) begin
                rpt_fire    = 1'b1;
                rpt_cnt_d   = '0;
                rpt_armed_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_cnt_q   <= '0;
            rpt_armed_q <= 1'b0;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_armed_q <= rpt_armed_d;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= '0;
            state_q     <= RELEASED;
            cnt_q       <= '0;
            incr_q      <= 1'b0;
            btn_level_q <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            incr_q      <= incr_d;
            btn_level_q <= btn_level_d;
        end
    end

    assign incr      = incr_q;
    assign btn_level = btn_level_q;

endmodule

// File: tb/tb_debounce_pulse.sv
// Scoreboard bench for debounce_pulse: a reference model predicts each cycle's outputs,
// plus directed checks on pulse timing, bounce rejection and reset behaviour.
module tb_debounce_pulse;

    localparam int STABLE = 4;
    localparam int RDELAY = 10;
    localparam int RPERIOD = 4;

    logic clk;
    logic rst;
    logic btn_in;
    logic incr;
    logic btn_level;

    typedef struct {
        logic incr;
        logic level;
    } exp_t;

    exp_t sb_q[$];
    int   pulse_log[$];
    int   level_hist[$];
    int   cycle_idx;
    int   checks;
    int   errors;

    logic m_sync1, m_sync2, m_level;
    int   m_run, m_since;

    debounce_pulse #(
        .STABLE_CYCLES(STABLE),
        .REPEAT_DELAY (RDELAY),
        .REPEAT_PERIOD(RPERIOD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_in   (btn_in),
        .incr     (incr),
        .btn_level(btn_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_sync1 = 1'b0;
        m_sync2 = 1'b0;
        m_level = 1'b0;
        m_run   = 0;
        m_since = 0;
        sb_q.delete();
    endtask

    // Level commits once STABLE consecutive synchronised samples disagree with it
    task automatic modelStep(input logic b, output logic exp_incr, output logic exp_level);
        logic s;
        s = m_sync2;
        exp_incr = 1'b0;
        if (s != m_level) m_run++;
        else m_run = 0;
        if (m_run == STABLE) begin
            m_level = s;
            m_run   = 0;
            if (s) begin
                exp_incr = 1'b1;
                m_since  = 0;
            end
        end else if (m_level) begin
`ifdef DEBOUNCE_AUTOREPEAT_EN
            m_since++;
            if (m_since == RDELAY || (m_since > RDELAY && ((m_since - RDELAY) % RPERIOD) == 0))
                exp_incr = 1'b1;
`endif
        end
        exp_level = m_level;
        m_sync2 = m_sync1;
        m_sync1 = b;
    endtask

    task automatic applyStimulus(input logic b);
        exp_t e;
        logic ei, el;
        @(negedge clk);
        btn_in = b;
        modelStep(b, ei, el);
        e.incr  = ei;
        e.level = el;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        checkOutput("incr", {31'd0, incr}, {31'd0, e.incr});
        checkOutput("btn_level", {31'd0, btn_level}, {31'd0, e.level});
        if (incr === 1'b1) pulse_log.push_back(cycle_idx);
        level_hist.push_back(int'(btn_level));
        cycle_idx++;
    endtask

    task automatic applyLevel(input logic b, input int n);
        for (int i = 0; i < n; i++) applyStimulus(b);
    endtask

    task automatic startPhase(output int base);
        pulse_log.delete();
        level_hist.delete();
        base = cycle_idx;
    endtask

    function automatic int firstPulse(input int base);
        return (pulse_log.size() > 0) ? pulse_log[0] - base : -1;
    endfunction

    function automatic int firstLow();
        for (int i = 0; i < level_hist.size(); i++)
            if (level_hist[i] == 0) return i;
        return -1;
    endfunction

    function automatic int levelOnes();
        int n = 0;
        for (int i = 0; i < level_hist.size(); i++) n += level_hist[i];
        return n;
    endfunction

    initial begin
        int base;
        int exp_rep[$];
        checks    = 0;
        errors    = 0;
        cycle_idx = 0;
        rst       = 1'b1;
        btn_in    = 1'b0;
        modelReset();

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_incr", {31'd0, incr}, 0);
        checkOutput("reset_level", {31'd0, btn_level}, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        modelReset();
        applyLevel(1'b0, 4);

        // Clean press then clean release
        startPhase(base);
        applyLevel(1'b1, 20);
        checkOutput("press_first_pulse", firstPulse(base), 5);
`ifdef DEBOUNCE_AUTOREPEAT_EN
        checkOutput("press_pulse_count", pulse_log.size(), 3);
`else
        checkOutput("press_pulse_count", pulse_log.size(), 1);
`endif
        checkOutput("press_level_pre_commit", level_hist[4], 0);
        checkOutput("press_level_commit", level_hist[5], 1);

        startPhase(base);
        applyLevel(1'b0, 10);
        checkOutput("release_first_low", firstLow(), 5);
`ifdef DEBOUNCE_AUTOREPEAT_EN
        checkOutput("release_pulse_count", pulse_log.size(), 1);
`else
        checkOutput("release_pulse_count", pulse_log.size(), 0);
`endif

        // Short glitch is invisible
        startPhase(base);
        applyLevel(1'b1, 3);
        applyLevel(1'b0, 10);
        checkOutput("glitch_pulse_count", pulse_log.size(), 0);
        checkOutput("glitch_level_ones", levelOnes(), 0);
        checkOutput("glitch_cnt_cleared", 32'(dut.cnt_q), 0);

        // Bouncy press: one pulse, timed from the final rise
        startPhase(base);
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        applyLevel(1'b1, 15);
        checkOutput("bouncy_first_pulse", firstPulse(base), 10);
        checkOutput("bouncy_pulse_count", pulse_log.size(), 1);

        // Release bounce keeps the press, then a real release
        startPhase(base);
        applyLevel(1'b0, 3);
        applyLevel(1'b1, 6);
        checkOutput("relbounce_level_ones", levelOnes(), 9);
`ifdef DEBOUNCE_AUTOREPEAT_EN
        checkOutput("relbounce_pulse_count", pulse_log.size(), 3);
`else
        checkOutput("relbounce_pulse_count", pulse_log.size(), 0);
`endif
        startPhase(base);
        applyLevel(1'b0, 10);
        checkOutput("relbounce_first_low", firstLow(), 5);
`ifdef DEBOUNCE_AUTOREPEAT_EN
        checkOutput("relbounce_rel_pulses", pulse_log.size(), 1);
`else
        checkOutput("relbounce_rel_pulses", pulse_log.size(), 0);
`endif

        // Reset asserted while incr is high, button held through reset release
        startPhase(base);
        applyLevel(1'b1, 6);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("midrst_incr", {31'd0, incr}, 0);
        checkOutput("midrst_level", {31'd0, btn_level}, 0);
        modelReset();
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        startPhase(base);
        applyLevel(1'b1, 10);
        checkOutput("requal_first_pulse", firstPulse(base), 5);
        checkOutput("requal_pulse_count", pulse_log.size(), 1);
        applyLevel(1'b0, 10);

`ifdef DEBOUNCE_AUTOREPEAT_EN
        // Held press repeats at commit+10 then every 4; a fresh press restarts the sequence
        exp_rep = '{5, 15, 19, 23, 27, 31, 35};
        startPhase(base);
        applyLevel(1'b1, 36);
        checkOutput("rep_pulse_count", pulse_log.size(), exp_rep.size());
        for (int i = 0; i < exp_rep.size(); i++)
            checkOutput($sformatf("rep_pulse_%0d", i),
                        (i < pulse_log.size()) ? pulse_log[i] - base : -1, exp_rep[i]);
        applyLevel(1'b0, 12);
        exp_rep = '{5, 15, 19};
        startPhase(base);
        applyLevel(1'b1, 20);
        checkOutput("rep2_pulse_count", pulse_log.size(), exp_rep.size());
        for (int i = 0; i < exp_rep.size(); i++)
            checkOutput($sformatf("rep2_pulse_%0d", i),
                        (i < pulse_log.size()) ? pulse_log[i] - base : -1, exp_rep[i]);
        applyLevel(1'b0, 12);
`endif

        checkOutput("scoreboard_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/debounce_pulse.md
Name: debounce_pulse

Overview:
- Upstream conditioning stage for the team's up-counter.
- Takes a raw, asynchronous, bouncy push-button level and synchronises and debounces it.
- Emits a single-cycle `incr` pulse per qualified press, which drives the counter's `incr` input directly.
- Also exports the debounced level for status LEDs and other logic.

Parameters:
- STABLE_CYCLES, 16: consecutive synchronised samples of a new level required before it is committed. Must be >= 1.
- REPEAT_DELAY, 32: cycles from commit of a press to the first auto-repeat pulse. Used only with the optional feature.
- REPEAT_PERIOD, 8: cycles between subsequent auto-repeat pulses. Used only with the optional feature.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- btn_in  input  1  raw button level, asynchronous to clk; 1 = pressed.
- incr  output  1  registered one-cycle pulse per committed press; feeds the counter `incr` input.
- btn_level  output  1  registered debounced button level.

Behaviour:
- Reset (asynchronous, active-high):
  - While rst=1, all flops clear immediately, independent of clk: synchroniser, FSM, stability counter, repeat counter.
  - Outputs during reset: incr=0, btn_level=0, FSM=RELEASED.
  - rst asserted mid-press drops incr and btn_level at once.
  - After rst deasserts, a button already held must requalify from scratch.
- Synchroniser:
  - Two-flop chain on btn_in; its output s is the only input the FSM sees.
- Stability counter:
  - Width is $clog2(STABLE_CYCLES+1).
  - Counts consecutive samples of s that differ from the committed level.
  - Cleared whenever s equals the committed level; never wraps.
- FSM states:
  - RELEASED: btn_level=0. If s=1, go to PRESS_WAIT and set count=1. If STABLE_CYCLES=1, go straight to PRESSED instead.
  - PRESS_WAIT: if s=0, return to RELEASED and clear count. Otherwise count++. When count reaches STABLE_CYCLES, go to PRESSED.
  - PRESSED: btn_level=1. If s=0, go to RELEASE_WAIT with count=1 (or straight to RELEASED if STABLE_CYCLES=1).
  - RELEASE_WAIT: if s=1, return to PRESSED and clear count. Otherwise count++. When count reaches STABLE_CYCLES, go to RELEASED.
- Outputs are registered and update on the committing edge:
  - Entry to PRESSED from PRESS_WAIT or RELEASED: incr=1 for exactly one cycle, btn_level=1.
  - Re-entry to PRESSED from RELEASE_WAIT: no pulse.
  - Entry to RELEASED from RELEASE_WAIT: btn_level=0, no pulse.
- Latency: btn_in rises before edge 0 and stays high. Then:
  - s=1 after edge 1.
  - Committing edge is edge STABLE_CYCLES+1.
  - incr is high only between edges STABLE_CYCLES+1 and STABLE_CYCLES+2.
  - Release has the same latency on btn_level.
- Boundary rules:
  - Any bounce shorter than STABLE_CYCLES samples is invisible at the outputs.
  - Back-to-back qualified presses need a qualified release between them.
  - Minimum spacing between pulses is 2*STABLE_CYCLES cycles.
- Elaboration error if STABLE_CYCLES < 1, or, with the feature enabled, if REPEAT_PERIOD < 1 or REPEAT_DELAY < 1.

Optional Feature:
- Macro name: DEBOUNCE_AUTOREPEAT_EN.
- Defined:
  - A repeat counter clears on the press-commit edge and runs while the FSM is in PRESSED or RELEASE_WAIT.
  - Extra incr pulses (one cycle each) occur REPEAT_DELAY cycles after the commit pulse, then every REPEAT_PERIOD cycles.
  - Leaving to RELEASED, or reset, clears the counter and stops repeats.
  - A repeat pulse never coincides with the commit pulse.
- Undefined:
  - No repeat logic is built and the REPEAT_* parameters are ignored.
  - Exactly one pulse per press.

Test Plan (STABLE_CYCLES=4 unless stated):
- Reset: assert rst between edges while the FSM is in PRESSED -> incr=0 and btn_level=0 before the next edge. Hold btn_in=1 through reset release -> pulse only after a full requalification (edge 5 after the first post-reset sample).
- Clean press: btn_in 0->1 before edge 0, held 20 cycles -> incr=1 only in the cycle after edge 5; btn_level=1 from edge 5; downstream count increases by exactly 1.
- Glitch: btn_in high for 3 cycles, then low -> incr never asserts; btn_level stays 0; stability counter back to 0.
- Bouncy press: btn_in pattern 1,0,1,1,0 then held 1 -> exactly one incr pulse, in the cycle after edge 5 counted from the final rise.
- Release bounce: from PRESSED, btn_in low 3 cycles then high -> btn_level stays 1, no pulse. Then btn_in low 10 cycles -> btn_level=0 at edge 5 after the fall, no incr.
- Auto-repeat (macro defined, REPEAT_DELAY=10, REPEAT_PERIOD=4): hold 30 cycles after commit -> pulses at commit and at commit+10, +14, +18, +22, +26, +30. Release stops pulses; a new press restarts the sequence.
